// File: rtl/calc_pkg.sv
// Shared key codes, sequencer state encoding and operand width helper
// for the keyboard calculator.
package calc_pkg;

  localparam logic [3:0] KEY_EQ   = 4'd10;
  localparam logic [3:0] KEY_NONE = 4'd11;
  localparam logic [3:0] OP_ADD   = 4'd12;
  localparam logic [3:0] OP_SUB   = 4'd13;
  localparam logic [3:0] OP_MUL   = 4'd14;
  localparam logic [3:0] OP_DIV   = 4'd15;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    CALC,
    CONV,
    SHOW
  } calc_state_t;

  // Binary width able to hold any DIGITS-digit decimal operand.
  function automatic int calc_opw(input int digits);
    return $clog2(10 ** digits);
  endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble: converts RW binary bits to 2*DIGITS BCD digits,
// one bit per cycle, exactly RW cycles after i_start.
module calc_bin2bcd
  import calc_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int RW     = 14
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [RW-1:0]       i_bin,
  output logic [8*DIGITS-1:0] o_bcd,
  output logic                o_done
);

  localparam int BW = 8 * DIGITS;
  localparam int CW = $clog2(RW + 1);

  logic [BW-1:0] r_bcd;
  logic [RW-1:0] r_bin;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int n = 0; n < 2 * DIGITS; n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5) begin
        w_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bcd <= '0;
      r_bin <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bcd <= '0;
      r_bin <= i_bin;
      r_cnt <= CW'(RW);
    end else if (r_cnt != '0) begin
      {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
      r_cnt          <= r_cnt - CW'(1);
    end
  end

  // High during the final shift, so the result is stable from the next cycle on.
  assign o_done = (r_cnt == CW'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/calc_seq.sv
// Calculator sequencer: two-operand decimal entry, shared iterative ALU
// (add/sub/shift-add multiply/restoring divide) and BCD result conversion.
module calc_seq
  import calc_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_key_valid,
  input  logic [3:0]          i_key_code,
  output logic [8*DIGITS-1:0] o_disp_bcd,
  output logic [3:0]          o_disp_op,
  output logic                o_neg,
  output logic                o_err,
  output logic                o_busy,
  output logic                o_done
);

  localparam int OPW = calc_opw(DIGITS);
  localparam int RW  = 2 * OPW;
  localparam int SW  = 4 * DIGITS;
  localparam int NW  = $clog2(DIGITS + 1);
  localparam int STW = $clog2(OPW + 1);
  localparam logic [RW-1:0] LIMIT = RW'(10 ** DIGITS);

  calc_state_t r_state, w_next;

  logic [OPW-1:0] r_a, r_b, r_q;
  logic [SW-1:0]  r_sha, r_shb;
  logic [NW-1:0]  r_cnta, r_cntb;
  logic [3:0]     r_op;
  logic           r_neg, r_err, r_done;
  logic [RW-1:0]  r_acc, r_sh, r_res;
  logic [STW-1:0] r_step;

  logic             w_digit, w_op, w_eq;
  logic [OPW-1:0]   w_acc_a, w_acc_b;
  logic [RW-1:0]    w_mul_acc, w_result;
  logic [OPW:0]     w_rem_sh;
  logic [OPW+1:0]   w_trial;
  logic             w_fits, w_calc_last, w_conv_done, w_conv_start;
  logic [OPW-1:0]   w_quo;
  logic [2*SW-1:0]  w_bcd;

  assign w_digit = i_key_valid && (i_key_code <= 4'd9);
  assign w_op    = i_key_valid && (i_key_code >= OP_ADD);
  assign w_eq    = i_key_valid && (i_key_code == KEY_EQ);

  assign w_acc_a = (r_a << 3) + (r_a << 1) + OPW'(i_key_code);
  assign w_acc_b = (r_b << 3) + (r_b << 1) + OPW'(i_key_code);

  always_comb begin
    w_mul_acc = r_q[0] ? (r_acc + r_sh) : r_acc;
    w_rem_sh  = {r_acc[OPW-1:0], r_q[OPW-1]};
    w_trial   = {1'b0, w_rem_sh} - {2'b00, r_b};
    w_fits    = !w_trial[OPW+1];
    w_quo     = {r_q[OPW-2:0], w_fits};
    case (r_op)
      OP_ADD:  w_result = RW'(r_a) + RW'(r_b);
      OP_SUB:  w_result = (r_a < r_b) ? RW'(r_b - r_a) : RW'(r_a - r_b);
      OP_MUL:  w_result = w_mul_acc;
      default: w_result = (r_b == '0) ? '0 : RW'(w_quo);
    endcase
    // Multiply and non-zero divide iterate OPW times; everything else is one cycle.
    if ((r_op == OP_MUL) || ((r_op == OP_DIV) && (r_b != '0))) begin
      w_calc_last = (r_step == STW'(OPW - 1));
    end else begin
      w_calc_last = 1'b1;
    end
  end

  assign w_conv_start = (r_state == CALC) && w_calc_last;

  calc_bin2bcd #(.DIGITS(DIGITS), .RW(RW)) u_bin2bcd (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_conv_start),
    .i_bin   (w_result),
    .o_bcd   (w_bcd),
    .o_done  (w_conv_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ENTER_A;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    case (r_state)
      ENTER_A: if (w_op) w_next = ENTER_B;
      ENTER_B: if (w_eq) w_next = CALC;
      CALC: begin
        o_busy = 1'b1;
        if (w_calc_last) w_next = CONV;
      end
      CONV: begin
        o_busy = 1'b1;
        if (w_conv_done) w_next = SHOW;
      end
      SHOW: begin
        if (w_digit)   w_next = ENTER_A;
        else if (w_op) w_next = ENTER_B;
      end
      default: w_next = ENTER_A;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_q    <= '0;
      r_sha  <= '0;
      r_shb  <= '0;
      r_cnta <= '0;
      r_cntb <= '0;
      r_op   <= OP_ADD;
      r_neg  <= 1'b0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
      r_acc  <= '0;
      r_sh   <= '0;
      r_res  <= '0;
      r_step <= '0;
    end else begin
      r_done <= (r_state == CONV) && w_conv_done;
      case (r_state)
        ENTER_A: begin
          if (w_digit && (r_cnta < NW'(DIGITS))) begin
            r_a    <= w_acc_a;
            r_sha  <= (r_sha << 4) | SW'(i_key_code);
            r_cnta <= r_cnta + NW'(1);
          end else if (w_op) begin
            r_op   <= i_key_code;
            r_b    <= '0;
            r_shb  <= '0;
            r_cntb <= '0;
          end
        end
        ENTER_B: begin
          if (w_digit && (r_cntb < NW'(DIGITS))) begin
            r_b    <= w_acc_b;
            r_shb  <= (r_shb << 4) | SW'(i_key_code);
            r_cntb <= r_cntb + NW'(1);
          end else if (w_op && (r_cntb == '0)) begin
            r_op <= i_key_code;
          end else if (w_eq) begin
            r_acc  <= '0;
            r_sh   <= RW'(r_a);
            r_q    <= (r_op == OP_DIV) ? r_a : r_b;
            r_step <= '0;
          end
        end
        CALC: begin
          r_step <= r_step + STW'(1);
          if (r_op == OP_MUL) begin
            r_acc <= w_mul_acc;
            r_sh  <= r_sh << 1;
            r_q   <= r_q >> 1;
          end else if (r_op == OP_DIV) begin
            r_acc <= RW'(w_fits ? w_trial[OPW:0] : w_rem_sh);
            r_q   <= w_quo;
          end
          if (w_calc_last) begin
            r_res <= w_result;
            r_neg <= (r_op == OP_SUB) && (r_a < r_b);
            r_err <= (r_op == OP_DIV) && (r_b == '0);
          end
        end
        SHOW: begin
          if (w_digit) begin
            r_neg  <= 1'b0;
            r_err  <= 1'b0;
            r_a    <= OPW'(i_key_code);
            r_sha  <= SW'(i_key_code);
            r_cnta <= NW'(1);
          end else if (w_op) begin
            // Only a representable, non-negative, error-free result seeds operand A.
            if ((r_res < LIMIT) && !r_neg && !r_err) begin
              r_a   <= r_res[OPW-1:0];
              r_sha <= w_bcd[SW-1:0];
            end else begin
              r_a   <= '0;
              r_sha <= '0;
            end
            r_neg  <= 1'b0;
            r_err  <= 1'b0;
            r_cnta <= '0;
            r_op   <= i_key_code;
            r_b    <= '0;
            r_shb  <= '0;
            r_cntb <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_state)
      ENTER_A: o_disp_bcd = {{SW{1'b0}}, r_sha};
      SHOW:    o_disp_bcd = w_bcd;
      default: o_disp_bcd = {{SW{1'b0}}, r_shb};
    endcase
  end

  assign o_disp_op = r_op;
  assign o_neg     = r_neg;
  assign o_err     = r_err;
  assign o_done    = r_done;

endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq: directed key-sequence table, busy/reset
// corner sequences and randomized calculations against a decimal arithmetic model.
module tb_calc_seq;

  logic        clk = 1'b0;
  logic        rstN;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic [15:0] dispBcd;
  logic [3:0]  dispOp;
  logic        neg, err, busy, done;

  int checks   = 0;
  int failures = 0;

  calc_seq #(.DIGITS(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_key_valid (keyValid),
    .i_key_code  (keyCode),
    .o_disp_bcd  (dispBcd),
    .o_disp_op   (dispOp),
    .o_neg       (neg),
    .o_err       (err),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  // Keys are packed first-key-in-the-top-nibble; expBusy of 0 means no calculation.
  typedef struct packed {
    logic [3:0]  nKeys;
    logic [31:0] keys;
    logic [15:0] expDisp;
    logic        expNeg;
    logic        expErr;
    logic [3:0]  expOp;
    logic [7:0]  expBusy;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] code);
    keyValid = 1'b1;
    keyCode  = code;
    @(negedge clk);
    keyValid = 1'b0;
  endtask

  // Counts cycles with busy high, starting at the negedge right after '=' is taken.
  task automatic waitCalc(output int cycles, output logic doneSeen);
    cycles = 0;
    while (busy && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    doneSeen = done;
  endtask

  task automatic checkResult(input string tag, input logic [15:0] expDisp,
                             input logic expNeg, input logic expErr,
                             input logic [3:0] expOp, input int expBusy);
    int   cycles;
    logic doneSeen;
    if (expBusy > 0) begin
      waitCalc(cycles, doneSeen);
      checkOutput({tag, "_busy_cycles"}, cycles, expBusy);
      checkOutput({tag, "_done"}, {31'b0, doneSeen}, 32'd1);
    end else begin
      checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
    end
    checkOutput({tag, "_disp"}, {16'b0, dispBcd}, {16'b0, expDisp});
    checkOutput({tag, "_neg"}, {31'b0, neg}, {31'b0, expNeg});
    checkOutput({tag, "_err"}, {31'b0, err}, {31'b0, expErr});
    checkOutput({tag, "_op"}, {28'b0, dispOp}, {28'b0, expOp});
  endtask

  function automatic logic [15:0] toBcd(input int value);
    logic [15:0] r;
    int v;
    v = value;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  initial begin
    int          cycles;
    logic        doneSeen;
    logic        sawDone;
    int          nA, nB, a, b, res, d, expBusy;
    logic [3:0]  op;
    logic        expNeg, expErr;
    string       tag;

    vecs[0]  = '{4'd6, 32'h42C17A00, 16'h0059, 1'b0, 1'b0, 4'hC, 8'd15};
    vecs[1]  = '{4'd6, 32'h99E99A00, 16'h9801, 1'b0, 1'b0, 4'hE, 8'd21};
    vecs[2]  = '{4'd4, 32'h3D5A0000, 16'h0002, 1'b1, 1'b0, 4'hD, 8'd15};
    vecs[3]  = '{4'd1, 32'h60000000, 16'h0006, 1'b0, 1'b0, 4'hD, 8'd0};
    vecs[4]  = '{4'd4, 32'h7F0A0000, 16'h0000, 1'b0, 1'b1, 4'hF, 8'd15};
    vecs[5]  = '{4'd4, 32'h8F3A0000, 16'h0002, 1'b0, 1'b0, 4'hF, 8'd21};
    vecs[6]  = '{4'd3, 32'h12300000, 16'h0012, 1'b0, 1'b0, 4'hF, 8'd0};
    vecs[7]  = '{4'd2, 32'hCD000000, 16'h0000, 1'b0, 1'b0, 4'hD, 8'd0};
    vecs[8]  = '{4'd2, 32'h5A000000, 16'h0007, 1'b0, 1'b0, 4'hD, 8'd15};
    vecs[9]  = '{4'd3, 32'hE2A00000, 16'h0014, 1'b0, 1'b0, 4'hE, 8'd21};
    vecs[10] = '{4'd1, 32'hB0000000, 16'h0014, 1'b0, 1'b0, 4'hE, 8'd0};
    vecs[11] = '{4'd7, 32'h25F123A0, 16'h0002, 1'b0, 1'b0, 4'hF, 8'd21};
    vecs[12] = '{4'd3, 32'hD0A00000, 16'h0002, 1'b0, 1'b0, 4'hD, 8'd15};
    vecs[13] = '{4'd4, 32'h1D9A0000, 16'h0008, 1'b1, 1'b0, 4'hD, 8'd15};
    vecs[14] = '{4'd3, 32'hC3A00000, 16'h0003, 1'b0, 1'b0, 4'hC, 8'd15};
    vecs[15] = '{4'd6, 32'h99C99A00, 16'h0198, 1'b0, 1'b0, 4'hC, 8'd15};
    vecs[16] = '{4'd3, 32'hC1A00000, 16'h0001, 1'b0, 1'b0, 4'hC, 8'd15};
    vecs[17] = '{4'd1, 32'hA0000000, 16'h0001, 1'b0, 1'b0, 4'hC, 8'd0};
    vecs[18] = '{4'd5, 32'h5AC3A000, 16'h0008, 1'b0, 1'b0, 4'hC, 8'd15};

    rstN     = 1'b0;
    keyValid = 1'b0;
    keyCode  = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_disp", {16'b0, dispBcd}, 32'h0);
    checkOutput("reset_op", {28'b0, dispOp}, 32'hC);
    checkOutput("reset_neg", {31'b0, neg}, 32'h0);
    checkOutput("reset_err", {31'b0, err}, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'h0);
    rstN = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k < int'(vecs[v].nKeys); k++) begin
        applyStimulus(vecs[v].keys[31-4*k -: 4]);
      end
      checkResult($sformatf("vec%0d", v), vecs[v].expDisp, vecs[v].expNeg,
                  vecs[v].expErr, vecs[v].expOp, int'(vecs[v].expBusy));
    end

    // Keys arriving during CALC and CONV must be dropped.
    applyStimulus(4'd4);
    applyStimulus(4'd14);
    applyStimulus(4'd6);
    applyStimulus(4'd10);
    cycles = 0;
    while (busy && cycles < 100) begin
      keyValid = (cycles == 3) || (cycles == 12);
      keyCode  = (cycles == 3) ? 4'd5 : 4'd12;
      @(negedge clk);
      cycles++;
    end
    keyValid = 1'b0;
    checkOutput("inject_busy_cycles", cycles, 32'd21);
    checkOutput("inject_done", {31'b0, done}, 32'd1);
    checkOutput("inject_disp", {16'b0, dispBcd}, 32'h0024);
    checkOutput("inject_op", {28'b0, dispOp}, 32'hE);

    // Reset in the middle of conversion discards the in-flight result.
    applyStimulus(4'd3);
    applyStimulus(4'd13);
    applyStimulus(4'd4);
    applyStimulus(4'd10);
    repeat (8) @(negedge clk);
    checkOutput("midconv_busy", {31'b0, busy}, 32'd1);
    checkOutput("midconv_neg", {31'b0, neg}, 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("rstconv_disp", {16'b0, dispBcd}, 32'h0);
    checkOutput("rstconv_busy", {31'b0, busy}, 32'h0);
    checkOutput("rstconv_neg", {31'b0, neg}, 32'h0);
    checkOutput("rstconv_op", {28'b0, dispOp}, 32'hC);
    @(negedge clk);
    rstN = 1'b1;
    sawDone = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("rstconv_no_done", {31'b0, sawDone}, 32'h0);
    applyStimulus(4'd7);
    checkOutput("rstconv_enter_a", {16'b0, dispBcd}, 32'h0007);
    applyStimulus(4'd12);
    applyStimulus(4'd2);
    applyStimulus(4'd10);
    checkResult("rstconv_calc", 16'h0009, 1'b0, 1'b0, 4'hC, 15);

    // Randomized calculations, each starting from SHOW with a fresh first digit.
    for (int t = 0; t < 30; t++) begin
      nA = $urandom_range(1, 3);
      nB = $urandom_range(0, 3);
      op = 4'($urandom_range(12, 15));
      a  = 0;
      b  = 0;
      for (int i = 0; i < nA; i++) begin
        d = $urandom_range(0, 9);
        applyStimulus(4'(d));
        if (i < 2) a = a * 10 + d;
      end
      if ($urandom_range(0, 1) == 1) applyStimulus(4'($urandom_range(12, 15)));
      applyStimulus(op);
      for (int i = 0; i < nB; i++) begin
        d = $urandom_range(0, 9);
        applyStimulus(4'(d));
        if (i < 2) b = b * 10 + d;
      end
      if (nB > 0 && $urandom_range(0, 1) == 1) applyStimulus(4'($urandom_range(12, 15)));
      applyStimulus(4'd10);
      expNeg = 1'b0;
      expErr = 1'b0;
      case (op)
        4'd12: res = a + b;
        4'd13: begin
          res    = (a < b) ? b - a : a - b;
          expNeg = (a < b);
        end
        4'd14: res = a * b;
        default: begin
          res    = (b == 0) ? 0 : a / b;
          expErr = (b == 0);
        end
      endcase
      expBusy = (op == 4'd14 || (op == 4'd15 && b != 0)) ? 21 : 15;
      tag = $sformatf("rnd%0d", t);
      checkResult(tag, toBcd(res), expNeg, expErr, op, expBusy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
